// File: rtl/tri_scan_iterator.sv
// ============================================================================
// Module  : tri_scan_iterator
// Brief   : Walks a triangle's bounding box row-major and emits one fragment
//           (x, y, z) per covered pixel over a valid/ready handshake.
//           Optional top-left fill rule: define RAST_TOP_LEFT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tri_scan_iterator #(
    parameter int X_RES        = 4,
    parameter int Y_RES        = 4,
    parameter int X_PIXEL_SIZE = $clog2(X_RES),
    parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
    parameter int Z_SIZE       = 8,
    parameter int ZFRAC        = 8,
    parameter int EDGE_W       = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [X_PIXEL_SIZE-1:0]   bbox_x_min_i,
    input  logic [X_PIXEL_SIZE-1:0]   bbox_x_max_i,
    input  logic [Y_PIXEL_SIZE-1:0]   bbox_y_min_i,
    input  logic [Y_PIXEL_SIZE-1:0]   bbox_y_max_i,
    input  logic [3*EDGE_W-1:0]       edge_init_i,
    input  logic [3*EDGE_W-1:0]       edge_dx_i,
    input  logic [3*EDGE_W-1:0]       edge_dy_i,
    input  logic [Z_SIZE+ZFRAC-1:0]   z_init_i,
    input  logic [Z_SIZE+ZFRAC-1:0]   z_dx_i,
    input  logic [Z_SIZE+ZFRAC-1:0]   z_dy_i,
    output logic                      frag_valid_o,
    input  logic                      frag_ready_i,
    output logic [X_PIXEL_SIZE-1:0]   frag_x_o,
    output logic [Y_PIXEL_SIZE-1:0]   frag_y_o,
    output logic [Z_SIZE-1:0]         frag_z_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int ZIN = Z_SIZE + ZFRAC;
    localparam int ZW  = Z_SIZE + ZFRAC + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    logic [X_PIXEL_SIZE-1:0]   r_x, r_x_min, r_x_max;
    logic [Y_PIXEL_SIZE-1:0]   r_y, r_y_max;
    logic signed [EDGE_W-1:0]  r_edge     [3];
    logic signed [EDGE_W-1:0]  r_edge_row [3];
    logic signed [EDGE_W-1:0]  r_edge_dx  [3];
    logic signed [EDGE_W-1:0]  r_edge_dy  [3];
    logic signed [ZW-1:0]      r_z, r_z_row, r_z_dx, r_z_dy;

    logic                      r_valid;
    logic [X_PIXEL_SIZE-1:0]   r_fx;
    logic [Y_PIXEL_SIZE-1:0]   r_fy;
    logic [Z_SIZE-1:0]         r_fz;

    logic [2:0]                w_lane_cov;
    logic                      w_covered;
    logic                      w_out_free;
    logic                      w_emit;
    logic                      w_advance;
    logic                      w_last;
    logic                      w_empty;
    logic [Z_SIZE-1:0]         w_zq;

    for (genvar k = 0; k < 3; k++) begin : g_lane
`ifdef RAST_TOP_LEFT_EN
        // Zero counts only on top-left edges so shared edges are drawn once.
        logic w_pos, w_zero, w_top_left;
        assign w_pos      = !r_edge[k][EDGE_W-1] && (|r_edge[k]);
        assign w_zero     = ~|r_edge[k];
        assign w_top_left = (!r_edge_dx[k][EDGE_W-1] && (|r_edge_dx[k]))
                          || ((~|r_edge_dx[k]) && r_edge_dy[k][EDGE_W-1]);
        assign w_lane_cov[k] = w_pos || (w_zero && w_top_left);
`else
        assign w_lane_cov[k] = !r_edge[k][EDGE_W-1];
`endif
    end

    assign w_covered  = &w_lane_cov;
    assign w_out_free = !r_valid || frag_ready_i;
    assign w_emit     = (r_state == S_SCAN) && w_covered && w_out_free;
    assign w_advance  = (r_state == S_SCAN) && (!w_covered || w_out_free);
    assign w_last     = (r_x == r_x_max) && (r_y == r_y_max);
    assign w_empty    = (bbox_x_max_i < bbox_x_min_i) || (bbox_y_max_i < bbox_y_min_i);

    always_comb begin
        if (r_z[ZW-1]) begin
            w_zq = '0;
        end else if (|r_z[ZW-2:ZIN]) begin
            w_zq = '1;
        end else begin
            w_zq = r_z[ZFRAC +: Z_SIZE];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // An empty box passes through DRAIN so done lands two cycles after start.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_nxt = w_empty ? S_DRAIN : S_SCAN;
            S_SCAN:  if (w_advance && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_out_free) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_fx    <= '0;
            r_fy    <= '0;
            r_fz    <= '0;
        end else begin
            if (w_emit) begin
                r_valid <= 1'b1;
                r_fx    <= r_x;
                r_fy    <= r_y;
                r_fz    <= w_zq;
            end else if (frag_ready_i) begin
                r_valid <= 1'b0;
            end

            if ((r_state == S_IDLE) && start_i) begin
                r_x_min <= bbox_x_min_i;
                r_x_max <= bbox_x_max_i;
                r_y_max <= bbox_y_max_i;
                r_x     <= bbox_x_min_i;
                r_y     <= bbox_y_min_i;
                for (int k = 0; k < 3; k++) begin
                    r_edge[k]     <= edge_init_i[k*EDGE_W +: EDGE_W];
                    r_edge_row[k] <= edge_init_i[k*EDGE_W +: EDGE_W];
                    r_edge_dx[k]  <= edge_dx_i[k*EDGE_W +: EDGE_W];
                    r_edge_dy[k]  <= edge_dy_i[k*EDGE_W +: EDGE_W];
                end
                r_z     <= {2'b00, z_init_i};
                r_z_row <= {2'b00, z_init_i};
                r_z_dx  <= {{2{z_dx_i[ZIN-1]}}, z_dx_i};
                r_z_dy  <= {{2{z_dy_i[ZIN-1]}}, z_dy_i};
            end else if (w_advance) begin
                if (r_x < r_x_max) begin
                    r_x <= r_x + 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        r_edge[k] <= r_edge[k] + r_edge_dx[k];
                    end
                    r_z <= r_z + r_z_dx;
                end else begin
                    r_x <= r_x_min;
                    r_y <= r_y + 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        r_edge_row[k] <= r_edge_row[k] + r_edge_dy[k];
                        r_edge[k]     <= r_edge_row[k] + r_edge_dy[k];
                    end
                    r_z_row <= r_z_row + r_z_dy;
                    r_z     <= r_z_row + r_z_dy;
                end
            end
        end
    end

    assign frag_valid_o = r_valid;
    assign frag_x_o     = r_fx;
    assign frag_y_o     = r_fy;
    assign frag_z_o     = r_fz;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_tri_scan_iterator.sv
// ============================================================================
// Module  : tb_tri_scan_iterator
// Brief   : Directed vector bench for tri_scan_iterator.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tri_scan_iterator;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  bbox_x_min_i, bbox_x_max_i, bbox_y_min_i, bbox_y_max_i;
    logic [47:0] edge_init_i, edge_dx_i, edge_dy_i;
    logic [15:0] z_init_i, z_dx_i, z_dy_i;
    logic        frag_valid_o, frag_ready_i;
    logic [1:0]  frag_x_o, frag_y_o;
    logic [7:0]  frag_z_o;
    logic        busy_o, done_o;

    always #5 clk = ~clk;

    tri_scan_iterator dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .bbox_x_min_i (bbox_x_min_i),
        .bbox_x_max_i (bbox_x_max_i),
        .bbox_y_min_i (bbox_y_min_i),
        .bbox_y_max_i (bbox_y_max_i),
        .edge_init_i  (edge_init_i),
        .edge_dx_i    (edge_dx_i),
        .edge_dy_i    (edge_dy_i),
        .z_init_i     (z_init_i),
        .z_dx_i       (z_dx_i),
        .z_dy_i       (z_dy_i),
        .frag_valid_o (frag_valid_o),
        .frag_ready_i (frag_ready_i),
        .frag_x_o     (frag_x_o),
        .frag_y_o     (frag_y_o),
        .frag_z_o     (frag_z_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    typedef struct {
        logic [1:0]  xmin, xmax, ymin, ymax;
        logic [47:0] ei, edx, edy;
        logic [15:0] zi, zdx, zdy;
        int          base;
        int          n;
        int          done_cyc;
    } vec_t;

    vec_t        vec [6];
    logic [11:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] x, input logic [1:0] y, input logic [7:0] z);
        exp_q.push_back({x, y, z});
    endtask

    task automatic load(input int vi);
        bbox_x_min_i = vec[vi].xmin;
        bbox_x_max_i = vec[vi].xmax;
        bbox_y_min_i = vec[vi].ymin;
        bbox_y_max_i = vec[vi].ymax;
        edge_init_i  = vec[vi].ei;
        edge_dx_i    = vec[vi].edx;
        edge_dy_i    = vec[vi].edy;
        z_init_i     = vec[vi].zi;
        z_dx_i       = vec[vi].zdx;
        z_dy_i       = vec[vi].zdy;
    endtask

    // stall_at: fragment index held off for 3 cycles; poke_at: cycle of a stray start pulse
    task automatic run(input int vi, input int stall_at, input int poke_at);
        int  k, cyc, base, n, exp_done;
        bit  got_done, stalled;
        base = vec[vi].base;
        n    = vec[vi].n;
        exp_done = vec[vi].done_cyc + ((stall_at >= 0) ? 3 : 0);
        k = 0; cyc = 1; got_done = 0; stalled = 0;
        load(vi);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        while (cyc <= 100 && !got_done) begin
            if (cyc == poke_at) begin
                start_i = 1'b1;
                bbox_x_max_i = 2'd0;
            end else if (cyc == poke_at + 1) begin
                start_i = 1'b0;
            end
            if (frag_valid_o) begin
                if (k == stall_at && !stalled) begin
                    stalled = 1;
                    frag_ready_i = 1'b0;
                    repeat (3) begin
                        @(posedge clk); #1;
                        cyc++;
                        chk("hold", {frag_valid_o, frag_x_o, frag_y_o, frag_z_o}, {1'b1, exp_q[base+k]});
                    end
                    frag_ready_i = 1'b1;
                end
                if (k < n) begin
                    chk($sformatf("vec%0d frag%0d", vi, k), {frag_x_o, frag_y_o, frag_z_o}, exp_q[base+k]);
                end
                k++;
            end
            if (done_o) begin
                got_done = 1;
                chk($sformatf("vec%0d done cycle", vi), cyc, exp_done);
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk($sformatf("vec%0d done seen", vi), {31'd0, got_done}, 1);
        chk($sformatf("vec%0d frag count", vi), k, n);
        @(posedge clk); #1;
        chk($sformatf("vec%0d idle after done", vi), {frag_valid_o, busy_o, done_o}, 0);
    endtask

    initial begin
        int k, cyc;
        rst_i = 1'b1; start_i = 1'b0; frag_ready_i = 1'b1;
        bbox_x_min_i = '0; bbox_x_max_i = '0; bbox_y_min_i = '0; bbox_y_max_i = '0;
        edge_init_i = '0; edge_dx_i = '0; edge_dy_i = '0;
        z_init_i = '0; z_dx_i = '0; z_dy_i = '0;

        // 0: full coverage, z = 5 + x + 2y
        vec[0] = '{2'd0, 2'd3, 2'd0, 2'd3, {16'd1, 16'd1, 16'd1}, 48'd0, 48'd0,
                   16'h0500, 16'h0100, 16'h0200, exp_q.size(), 0, 18};
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                add(x[1:0], y[1:0], 8'(5 + x + 2*y));
        vec[0].n = exp_q.size() - vec[0].base;

        // 1: lane0 culls x >= 2; last pixel (3,1) uncovered
        vec[1] = '{2'd0, 2'd3, 2'd0, 2'd1, {16'd1, 16'd1, 16'd1}, {16'd0, 16'd0, 16'hFFFF}, 48'd0,
                   16'h0000, 16'h0100, 16'h1000, exp_q.size(), 0, 10};
        add(2'd0, 2'd0, 8'h00); add(2'd1, 2'd0, 8'h01);
        add(2'd0, 2'd1, 8'h10); add(2'd1, 2'd1, 8'h11);
        vec[1].n = exp_q.size() - vec[1].base;

        // 2: saturation high
        vec[2] = '{2'd0, 2'd3, 2'd0, 2'd0, {16'd1, 16'd1, 16'd1}, 48'd0, 48'd0,
                   16'hFF00, 16'h0200, 16'h0000, exp_q.size(), 0, 6};
        for (int x = 0; x < 4; x++) add(x[1:0], 2'd0, 8'd255);
        vec[2].n = exp_q.size() - vec[2].base;

        // 3: saturation low
        vec[3] = '{2'd0, 2'd3, 2'd0, 2'd0, {16'd1, 16'd1, 16'd1}, 48'd0, 48'd0,
                   16'h0100, 16'hFE00, 16'h0000, exp_q.size(), 0, 6};
        add(2'd0, 2'd0, 8'd1); add(2'd1, 2'd0, 8'd0);
        add(2'd2, 2'd0, 8'd0); add(2'd3, 2'd0, 8'd0);
        vec[3].n = exp_q.size() - vec[3].base;

        // 4: zero edge, dx = -1 (not top-left)
        vec[4] = '{2'd0, 2'd0, 2'd0, 2'd0, {16'd1, 16'd1, 16'd0}, {16'd0, 16'd0, 16'hFFFF}, 48'd0,
                   16'h2A00, 16'h0000, 16'h0000, exp_q.size(), 0, 3};
`ifndef RAST_TOP_LEFT_EN
        add(2'd0, 2'd0, 8'd42);
`endif
        vec[4].n = exp_q.size() - vec[4].base;

        // 5: zero edge, dx = +1 (top-left)
        vec[5] = '{2'd0, 2'd0, 2'd0, 2'd0, {16'd1, 16'd1, 16'd0}, {16'd0, 16'd0, 16'h0001}, 48'd0,
                   16'h2A00, 16'h0000, 16'h0000, exp_q.size(), 0, 3};
        add(2'd0, 2'd0, 8'd42);
        vec[5].n = exp_q.size() - vec[5].base;

        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {frag_valid_o, frag_x_o, frag_y_o, frag_z_o, busy_o, done_o}, 0);
        rst_i = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run(i, -1, -1);

        run(0, 2, -1);      // backpressure on (2,0)
        run(0, -1, 5);      // stray start mid-scan

        // empty bounding box
        load(0);
        bbox_x_min_i = 2'd3; bbox_x_max_i = 2'd1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("empty c1", {frag_valid_o, busy_o, done_o}, 3'b010);
        @(posedge clk); #1;
        chk("empty c2", {frag_valid_o, busy_o, done_o}, 3'b011);
        @(posedge clk); #1;
        chk("empty c3", {frag_valid_o, busy_o, done_o}, 3'b000);

        // reset after the 5th fragment handshake
        load(0);
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        k = 0; cyc = 0;
        while (k < 5 && cyc < 100) begin
            if (frag_valid_o) k++;
            @(posedge clk); #1;
            cyc++;
        end
        chk("rst reached 5 frags", k, 5);
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk("mid-scan reset outputs", {frag_valid_o, frag_x_o, frag_y_o, frag_z_o, busy_o, done_o}, 0);
        rst_i = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("post-reset quiet", {frag_valid_o, busy_o, done_o}, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
